// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer with start/halt control, branch
// redirection with a single bubble cycle, and a valid/ready fetch handshake.
// All state, including pc and wrap, is registered; fetch_valid and busy are
// decoded from the state register, so every output changes only on clk edges.

module pc_sequencer #(
   parameter int unsigned      WIDTH    = 8,
   parameter int unsigned      STEP     = 1,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             fetch_ready,
   output logic             fetch_valid,
   output logic [WIDTH-1:0] pc,
   output logic             busy,
   output logic             wrap
);

   // One extra bit so the carry out of pc + STEP is visible as the wrap flag.
   localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StBranch = 2'd2,
      StHalted = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH:0]   pc_inc;

   assign pc_inc = {1'b0, pc_q} + STEP_EXT;

   // State, pc and wrap registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wrap_q  <= wrap_d;
      end
   end

   // Next-state and next-pc: halt > br_valid > start > fetch handshake.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wrap_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // halt has no meaning before sequencing has begun.
            if (br_valid) begin
               pc_d = br_target;
            end else if (start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (halt) begin
               state_d = StHalted;
            end else if (br_valid) begin
               // A same-cycle handshake is dropped; the target is offered after the bubble.
               pc_d    = br_target;
               state_d = StBranch;
            end else if (fetch_ready) begin
               pc_d   = pc_inc[WIDTH-1:0];
               wrap_d = pc_inc[WIDTH];
            end
         end
         StBranch: begin
            if (halt) begin
               state_d = StHalted;
            end else if (br_valid) begin
               // Back-to-back branch restarts the bubble at the new target.
               pc_d = br_target;
            end else begin
               state_d = StRun;
            end
         end
         StHalted: begin
            if (!halt) begin
               if (br_valid) begin
                  pc_d = br_target;
               end else if (start) begin
                  state_d = StRun;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded straight from registered state.
   always_comb begin
      fetch_valid = (state_q == StRun);
      busy        = (state_q == StRun) || (state_q == StBranch);
      pc          = pc_q;
      wrap        = wrap_q;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer (WIDTH=8, STEP=1, RESET_PC=0): directed scenarios with
// hand-computed expectations, then random stimulus against a reference model.

module tb_pc_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic       halt;
   logic       br_valid;
   logic [7:0] br_target;
   logic       fetch_ready;
   logic       fetch_valid;
   logic [7:0] pc;
   logic       busy;
   logic       wrap;

   typedef struct packed {
      logic [7:0] pc;
      logic       fv;
      logic       busy;
      logic       wrap;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   // Reference model state: 0 idle, 1 run, 2 branch, 3 halted.
   int         m_state;
   logic [7:0] m_pc;
   logic       m_wrap;

   pc_sequencer #(
      .WIDTH    (8),
      .STEP     (1),
      .RESET_PC (8'h00)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .halt        (halt),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .pc          (pc),
      .busy        (busy),
      .wrap        (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the expected post-edge outputs, then
   // pop and compare them 1 ns after the rising edge.
   task automatic cycle(input string tag, input logic r, input logic s, input logic h,
                        input logic bv, input logic [7:0] bt, input logic fr,
                        input logic [7:0] e_pc, input logic e_fv, input logic e_busy,
                        input logic e_wrap);
      exp_t  e;
      string t;
      reset       = r;
      start       = s;
      halt        = h;
      br_valid    = bv;
      br_target   = bt;
      fetch_ready = fr;
      exp_q.push_back('{pc: e_pc, fv: e_fv, busy: e_busy, wrap: e_wrap});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".pc"},   32'(pc),          32'(e.pc));
      check({t, ".fv"},   32'(fetch_valid), 32'(e.fv));
      check({t, ".busy"}, 32'(busy),        32'(e.busy));
      check({t, ".wrap"}, 32'(wrap),        32'(e.wrap));
   endtask

   // Reference behaviour for one clock edge.
   task automatic model_step(input logic r, input logic s, input logic h, input logic bv,
                             input logic [7:0] bt, input logic fr);
      if (r) begin
         m_state = 0;
         m_pc    = 8'h00;
         m_wrap  = 1'b0;
      end else begin
         m_wrap = 1'b0;
         case (m_state)
            0: begin
               if (bv) m_pc = bt;
               else if (s) m_state = 1;
            end
            1: begin
               if (h) m_state = 3;
               else if (bv) begin
                  m_pc    = bt;
                  m_state = 2;
               end else if (fr) begin
                  m_wrap = (m_pc == 8'hFF);
                  m_pc   = m_pc + 8'd1;
               end
            end
            2: begin
               if (h) m_state = 3;
               else if (bv) m_pc = bt;
               else m_state = 1;
            end
            default: begin
               if (!h) begin
                  if (bv) m_pc = bt;
                  else if (s) m_state = 1;
               end
            end
         endcase
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; halt = 1'b0; br_valid = 1'b0;
      br_target = 8'h00; fetch_ready = 1'b0;

      //    tag          rst st h bv tgt    fr  pc     fv busy wrap
      cycle("reset0",     1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
      cycle("reset1",     1, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0);
      cycle("start",      0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 1, 0);
      cycle("seq1",       0, 0, 0, 0, 8'h00, 1, 8'h01, 1, 1, 0);
      cycle("seq2",       0, 0, 0, 0, 8'h00, 1, 8'h02, 1, 1, 0);
      cycle("seq3",       0, 0, 0, 0, 8'h00, 1, 8'h03, 1, 1, 0);
      cycle("seq4",       0, 0, 0, 0, 8'h00, 1, 8'h04, 1, 1, 0);
      cycle("stall",      0, 0, 0, 0, 8'h00, 0, 8'h04, 1, 1, 0);
      cycle("br_fe",      0, 0, 0, 1, 8'hFE, 0, 8'hFE, 0, 1, 0);
      cycle("bubble_fe",  0, 0, 0, 0, 8'h00, 0, 8'hFE, 1, 1, 0);
      cycle("inc_ff",     0, 0, 0, 0, 8'h00, 1, 8'hFF, 1, 1, 0);
      cycle("wrap_00",    0, 0, 0, 0, 8'h00, 1, 8'h00, 1, 1, 1);
      cycle("wrap_clr",   0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 0);
      cycle("br_10",      0, 0, 0, 1, 8'h10, 1, 8'h10, 0, 1, 0);
      cycle("run_10",     0, 0, 0, 0, 8'h00, 0, 8'h10, 1, 1, 0);
      cycle("br_80_hs",   0, 0, 0, 1, 8'h80, 1, 8'h80, 0, 1, 0);
      cycle("bubble_80",  0, 0, 0, 0, 8'h00, 1, 8'h80, 1, 1, 0);
      cycle("inc_81",     0, 0, 0, 0, 8'h00, 1, 8'h81, 1, 1, 0);
      cycle("br_20",      0, 0, 0, 1, 8'h20, 0, 8'h20, 0, 1, 0);
      cycle("br_in_br",   0, 0, 0, 1, 8'h30, 0, 8'h30, 0, 1, 0);
      cycle("run_30",     0, 0, 0, 0, 8'h00, 0, 8'h30, 1, 1, 0);
      cycle("br_20b",     0, 0, 0, 1, 8'h20, 0, 8'h20, 0, 1, 0);
      cycle("run_20",     0, 0, 0, 0, 8'h00, 0, 8'h20, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cycle("hold_20",  0, 0, 0, 0, 8'h00, 0, 8'h20, 1, 1, 0);
      end
      cycle("halt_br",    0, 0, 1, 1, 8'h55, 1, 8'h20, 0, 0, 0);
      cycle("halt_start", 0, 1, 1, 0, 8'h00, 0, 8'h20, 0, 0, 0);
      cycle("halt_br33",  0, 0, 0, 1, 8'h33, 0, 8'h33, 0, 0, 0);
      cycle("resume",     0, 1, 0, 0, 8'h00, 0, 8'h33, 1, 1, 0);
      cycle("reset_run",  1, 0, 0, 1, 8'h99, 1, 8'h00, 0, 0, 0);
      cycle("idle_halt",  0, 1, 1, 0, 8'h00, 0, 8'h00, 1, 1, 0);
      cycle("br_ff",      0, 0, 0, 1, 8'hFF, 0, 8'hFF, 0, 1, 0);
      cycle("run_ff",     0, 0, 0, 0, 8'h00, 0, 8'hFF, 1, 1, 0);
      cycle("br_nowrap",  0, 0, 0, 1, 8'h00, 1, 8'h00, 0, 1, 0);
      cycle("halt_br_st", 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
      cycle("reset2",     1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
      cycle("idle_br_st", 0, 1, 0, 1, 8'h44, 1, 8'h44, 0, 0, 0);
      cycle("idle_start", 0, 1, 0, 0, 8'h00, 1, 8'h44, 1, 1, 0);

      // Random phase, model starts from reset.
      model_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle("rnd_reset", 1, 0, 0, 0, 8'h00, 0, m_pc, 1'b0, 1'b0, m_wrap);
      for (int i = 0; i < 400; i++) begin
         logic       r, s, h, bv, fr;
         logic [7:0] bt;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 20);
         h  = ($urandom_range(0, 99) < 8);
         bv = ($urandom_range(0, 99) < 12);
         fr = ($urandom_range(0, 99) < 70);
         bt = ($urandom_range(0, 3) == 0) ? 8'hFD : 8'($urandom_range(0, 255));
         model_step(r, s, h, bv, bt, fr);
         cycle($sformatf("rnd%0d", i), r, s, h, bv, bt, fr, m_pc, (m_state == 1),
               (m_state == 1) || (m_state == 2), m_wrap);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
